// File: rtl/engine_scheduler.sv
// engine_scheduler: hands raster-ordered pixel coordinates to a pool of
// Mandelbrot engines, round-robin over whichever engines are free.
// Optional stall counter enabled by defining ENGINE_SCHEDULER_PERF_EN;
// without it stall_cycles is tied to zero.
//
// state    | meaning
// IDLE     | waiting for start
// DISPATCH | issuing pixels to free engines, one grant per cycle at most
// DRAIN    | every pixel issued, waiting for engines to retire
// DONE     | one-cycle frame_done, then back to IDLE
module engine_scheduler #(
    parameter int NUM_ENGINES      = 8,
    parameter int PIXEL_DATA_WIDTH = 10,
    parameter int X_SIZE           = 640,
    parameter int Y_SIZE           = 480
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        hold,
    input  logic [NUM_ENGINES-1:0]      engine_fin,
    output logic [NUM_ENGINES-1:0]      grant,
    output logic [PIXEL_DATA_WIDTH-1:0] dispatch_x,
    output logic [PIXEL_DATA_WIDTH-1:0] dispatch_y,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        protocol_err,
    output logic [31:0]                 stall_cycles
);
    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t                      state;
    state_t                      state_next;
    logic [NUM_ENGINES-1:0]      outstanding;
    logic [PTR_W-1:0]            pointer;
    logic [PIXEL_DATA_WIDTH-1:0] pos_x;
    logic [PIXEL_DATA_WIDTH-1:0] pos_y;

    logic                        found;
    logic [PTR_W-1:0]            pick;
    logic                        issue;
    logic [NUM_ENGINES-1:0]      pick_onehot;
    logic                        last_x;
    logic                        last_pixel;
    logic                        frame_start;

    // Find the first free engine at or above the pointer, wrapping around.
    // An engine whose fin arrives this edge is still seen as busy here.
    always_comb begin
        logic [PTR_W:0] sum;
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            sum = {1'b0, pointer} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_ENGINES)) begin
                sum = sum - (PTR_W+1)'(NUM_ENGINES);
            end
            if (!found && !outstanding[sum[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[PTR_W-1:0];
            end
        end
    end

    assign issue       = (state == DISPATCH) && !hold && found;
    assign pick_onehot = issue ? (NUM_ENGINES'(1) << pick) : '0;
    assign last_x      = (pos_x == PIXEL_DATA_WIDTH'(X_SIZE - 1));
    assign last_pixel  = last_x && (pos_y == PIXEL_DATA_WIDTH'(Y_SIZE - 1));
    assign frame_start = (state == IDLE) && start;

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = DISPATCH;
            end
            DISPATCH: begin
                if (issue && last_pixel) state_next = DRAIN;
            end
            DRAIN: begin
                if (outstanding == '0) state_next = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Engine bookkeeping: outstanding mask and sticky protocol error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding  <= '0;
            protocol_err <= 1'b0;
        end else begin
            outstanding  <= (outstanding & ~engine_fin) | pick_onehot;
            protocol_err <= protocol_err | (|(engine_fin & ~outstanding));
        end
    end

    // Grant/coordinate registers, round-robin pointer and raster position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant      <= '0;
            dispatch_x <= '0;
            dispatch_y <= '0;
            pointer    <= '0;
            pos_x      <= '0;
            pos_y      <= '0;
        end else begin
            grant <= pick_onehot;
            if (frame_start) begin
                pos_x <= '0;
                pos_y <= '0;
            end else if (issue) begin
                dispatch_x <= pos_x;
                dispatch_y <= pos_y;
                pointer    <= (pick == PTR_W'(NUM_ENGINES - 1)) ? '0 : pick + PTR_W'(1);
                if (last_x) begin
                    pos_x <= '0;
                    pos_y <= pos_y + PIXEL_DATA_WIDTH'(1);
                end else begin
                    pos_x <= pos_x + PIXEL_DATA_WIDTH'(1);
                end
            end
        end
    end

`ifdef ENGINE_SCHEDULER_PERF_EN
    logic [31:0] stall_count;

    // Count DISPATCH cycles that could not issue; saturates, restarts per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (frame_start) begin
            stall_count <= '0;
        end else if ((state == DISPATCH) && !issue && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

    assign stall_cycles = stall_count;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: doc/engine_scheduler.md
ENGINE_SCHEDULER -- requirements
Module: engine_scheduler

Interface
REQ-001 Parameter NUM_ENGINES, default 8, number of Mandelbrot engines served.
REQ-002 Parameter PIXEL_DATA_WIDTH, default 10, width of pixel coordinates.
REQ-003 Parameter X_SIZE, default 640, pixels per line.
REQ-004 Parameter Y_SIZE, default 480, lines per frame.
REQ-005 Port clk  input  1  single clock; all state on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port start  input  1  begin a frame; sampled only in IDLE.
REQ-008 Port hold  input  1  back-pressure (e.g. any queue full); blocks new grants.
REQ-009 Port engine_fin  input  NUM_ENGINES  per-engine one-cycle pulse: current pixel finished.
REQ-010 Port grant  output  NUM_ENGINES  one-hot or zero; registered; engine i takes dispatch_x/y when grant[i]=1.
REQ-011 Port dispatch_x  output  PIXEL_DATA_WIDTH  registered x coordinate accompanying grant.
REQ-012 Port dispatch_y  output  PIXEL_DATA_WIDTH  registered y coordinate accompanying grant.
REQ-013 Port busy  output  1  high in any state except IDLE.
REQ-014 Port frame_done  output  1  one-cycle pulse when last pixel of frame has retired.
REQ-015 Port protocol_err  output  1  sticky flag: engine_fin on an engine with nothing outstanding.
REQ-016 Port stall_cycles  output  32  count of DISPATCH cycles with hold=1 or no free engine.

Function
REQ-017 States IDLE, DISPATCH, DRAIN, DONE; IDLE->DISPATCH on start=1; DISPATCH->DRAIN on edge that grants pixel (X_SIZE-1, Y_SIZE-1); DRAIN->DONE when outstanding mask is all zero; DONE->IDLE unconditionally after one cycle.
REQ-018 Per-engine outstanding bit: set on the edge that asserts grant[i], cleared on the edge sampling engine_fin[i]=1; engine is free when its bit is 0.
REQ-019 In DISPATCH, each edge with hold=0 and at least one free engine issues exactly one grant: first free engine at or above round-robin pointer, wrapping at NUM_ENGINES.
REQ-020 After a grant to engine i, pointer becomes (i+1) mod NUM_ENGINES; pointer unchanged when no grant.
REQ-021 grant/dispatch_x/dispatch_y valid for exactly one cycle per issue; grant=0 otherwise, dispatch_x/y hold last value.
REQ-022 Raster order: x increments 0..X_SIZE-1, wraps to 0 with y+1; y runs 0..Y_SIZE-1; no pixel skipped or repeated.
REQ-023 Latency: start sampled at edge k -> DISPATCH after edge k; first grant (pixel 0,0) visible after edge k+1 if hold=0.
REQ-024 engine_fin[i] and grant to engine j!=i on same edge: both applied; engine i eligible from the next edge only.
REQ-025 engine_fin[i] with outstanding[i]=0: ignored for state, sets protocol_err (cleared only by reset).
REQ-026 hold=1 in DISPATCH: no grant, raster position and pointer frozen; hold ignored in DRAIN.
REQ-027 start while busy: ignored; start held high through DONE starts a new frame from IDLE next cycle.
REQ-028 frame_done asserted only during DONE; busy=0 only in IDLE.

Reset
REQ-029 On reset: state IDLE, grant=0, dispatch_x=0, dispatch_y=0, outstanding=0, pointer=0, frame_done=0, protocol_err=0, stall_cycles=0, busy=0.
REQ-030 Reset mid-frame abandons frame; no frame_done; in-flight engine_fin after reset sets protocol_err.

Configuration
REQ-031 Macro ENGINE_SCHEDULER_PERF_EN defined: stall_cycles counts as REQ-016, saturating at 32'hFFFF_FFFF, cleared on reset and on IDLE->DISPATCH.
REQ-032 Macro undefined: no counter logic; stall_cycles tied to 0; all other behaviour identical.

Verification (bench: NUM_ENGINES=4, X_SIZE=4, Y_SIZE=2)
REQ-033 Reset, start pulse, engines finish 3 cycles after each grant -> 8 grants in order (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1), engines 0,1,2,3,0,1,2,3, one frame_done pulse, busy low after.
REQ-034 No engine_fin ever -> grants to engines 0..3 with pixels (0,0)..(3,0), then no grants; stall_cycles increments each cycle (PERF_EN).
REQ-035 hold=1 for 5 cycles after second grant -> no grants for those cycles, third grant is (2,0) to engine 2.
REQ-036 engine_fin[2] pulsed with nothing outstanding -> protocol_err=1 and stays 1; grant sequence unaffected.
REQ-037 Assert reset during DISPATCH after 3 grants -> all outputs at reset values next cycle; new start restarts at (0,0) engine 0.
REQ-038 engine_fin[0] on same edge engine 1 granted, engines 2,3 busy -> next grant goes to engine 0 (pointer wrap), not earlier.
